// File: rtl/i2s_capture_ctrl.sv
// I2S capture sequencer: receiver enable, start-up sample skip, channel filter, frame count, show-ahead FIFO.
// Optional watchdog (sticky timeout flag) when I2S_CAPTURE_TIMEOUT_EN is defined.
module i2s_capture_ctrl #(
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter int unsigned DW             = 24,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                            HCLK,
    input  logic                            HRESET,
    input  logic                            start,
    input  logic                            stop,
    input  logic [15:0]                     frame_len,
    input  logic [7:0]                      skip_cnt,
    input  logic [1:0]                      chan_sel,
    output logic                            i2s_en,
    input  logic [31:0]                     s_data,
    input  logic                            s_done,
    input  logic                            s_ws,
    input  logic                            fifo_rd,
    output logic [DW-1:0]                   fifo_rdata,
    output logic                            fifo_empty,
    output logic                            fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            busy,
    output logic                            frame_done,
    output logic                            overrun,
    input  logic                            clr_ovr,
    output logic                            timeout
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      skip_q, skip_d;
    logic [15:0]     count_q, count_d;
    logic [15:0]     flen_q, flen_d;
    logic [1:0]      csel_q, csel_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            empty_q, empty_d;
    logic            full_q, full_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            busy_q, busy_d;
    logic            frame_done_q, frame_done_d;
    logic            overrun_q, overrun_d;
    logic [DW-1:0]   mem [FIFO_DEPTH];

    logic            match_c;
    logic            push_c;
    logic            pop_c;
    logic            drop_c;
    logic [DW-1:0]   samp_c;
    logic [AW-1:0]   rd_nxt_addr_c;

`ifdef I2S_CAPTURE_TIMEOUT_EN
    logic [15:0]     wdog_q, wdog_d;
    logic            timeout_q, timeout_d;
`endif

    assign match_c       = s_done & (csel_q[1] | (s_ws == csel_q[0]));
    assign samp_c        = s_data[31 -: DW];
    assign pop_c         = fifo_rd & ~empty_q;
    assign rd_nxt_addr_c = rd_ptr_q[AW-1:0] + AW'(1);

    // Sequencer, FIFO pointer and flag next-state logic
    always_comb begin
        state_d      = state_q;
        skip_d       = skip_q;
        count_d      = count_q;
        flen_d       = flen_q;
        csel_d       = csel_q;
        frame_done_d = 1'b0;
        push_c       = 1'b0;
        drop_c       = 1'b0;
`ifdef I2S_CAPTURE_TIMEOUT_EN
        wdog_d       = wdog_q;
        timeout_d    = timeout_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    skip_d  = skip_cnt;
                    count_d = '0;
                    flen_d  = frame_len;
                    csel_d  = chan_sel;
                    state_d = (skip_cnt == 8'd0) ? ST_CAPTURE : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (match_c) begin
                    skip_d = skip_q - 8'd1;
                    if (skip_q == 8'd1) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (match_c) begin
                    // a dropped sample still occupies a frame slot
                    if (!full_q || fifo_rd) begin
                        push_c = 1'b1;
                    end else begin
                        drop_c = 1'b1;
                    end
                    count_d = count_q + 16'd1;
                    if ((flen_q != 16'd0) && (count_d == flen_q)) begin
                        frame_done_d = 1'b1;
                        state_d      = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef I2S_CAPTURE_TIMEOUT_EN
        if (state_q == ST_IDLE) begin
            if (start && !stop) begin
                wdog_d    = '0;
                timeout_d = 1'b0;
            end
        end else if (s_done) begin
            wdog_d = '0;
        end else if (!stop && (wdog_q == 16'(TIMEOUT_CYCLES - 1))) begin
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
        end else begin
            wdog_d = wdog_q + 16'd1;
        end
`endif

        busy_d    = (state_d != ST_IDLE);
        overrun_d = (overrun_q & ~clr_ovr) | drop_c;

        wr_ptr_d = wr_ptr_q + LW'(push_c);
        rd_ptr_d = rd_ptr_q + LW'(pop_c);
        level_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);

        // Head register: a push becomes the head only when nothing else would be left
        rdata_d = rdata_q;
        if (push_c && (empty_q || (pop_c && (level_q == LW'(1))))) begin
            rdata_d = samp_c;
        end else if (pop_c && (level_q > LW'(1))) begin
            rdata_d = mem[rd_nxt_addr_c];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q      <= ST_IDLE;
            skip_q       <= '0;
            count_q      <= '0;
            flen_q       <= '0;
            csel_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_q       <= skip_d;
            count_q      <= count_d;
            flen_q       <= flen_d;
            csel_q       <= csel_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge HCLK) begin
        if (push_c) begin
            mem[wr_ptr_q[AW-1:0]] <= samp_c;
        end
    end

`ifdef I2S_CAPTURE_TIMEOUT_EN
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    generate
        if (DW < 32) begin : g_unused_lsbs
            logic unused_lsbs;
            assign unused_lsbs = ^s_data[31-DW:0];
        end
    endgenerate

    assign i2s_en     = busy_q;
    assign busy       = busy_q;
    assign fifo_rdata = rdata_q;
    assign fifo_empty = empty_q;
    assign fifo_full  = full_q;
    assign fifo_level = level_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_i2s_capture_ctrl.sv
// Directed bench for i2s_capture_ctrl (FIFO_DEPTH=4, TIMEOUT_CYCLES=100); table of per-cycle vectors plus corner sequences.
module tb_i2s_capture_ctrl;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DW    = 24;

    logic        HCLK, HRESET;
    logic        start, stop, s_done, s_ws, fifo_rd, clr_ovr;
    logic [15:0] frame_len;
    logic [7:0]  skip_cnt;
    logic [1:0]  chan_sel;
    logic [31:0] s_data;
    logic        i2s_en, fifo_empty, fifo_full, busy, frame_done, overrun, timeout;
    logic [DW-1:0] fifo_rdata;
    logic [2:0]  fifo_level;

    int n_chk  = 0;
    int n_fail = 0;

    i2s_capture_ctrl #(
        .FIFO_DEPTH    (DEPTH),
        .DW            (DW),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .start     (start),
        .stop      (stop),
        .frame_len (frame_len),
        .skip_cnt  (skip_cnt),
        .chan_sel  (chan_sel),
        .i2s_en    (i2s_en),
        .s_data    (s_data),
        .s_done    (s_done),
        .s_ws      (s_ws),
        .fifo_rd   (fifo_rd),
        .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty),
        .fifo_full (fifo_full),
        .fifo_level(fifo_level),
        .busy      (busy),
        .frame_done(frame_done),
        .overrun   (overrun),
        .clr_ovr   (clr_ovr),
        .timeout   (timeout)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    typedef struct {
        logic        st, sp, sd, ws;
        logic [31:0] data;
        logic        rd, clr;
        logic [15:0] fl;
        logic [7:0]  sk;
        logic [1:0]  cs;
        logic        e_busy, e_empty, e_full;
        logic [2:0]  e_lvl;
        logic [23:0] e_rdata;
        logic        e_fd, e_ovr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic st, input logic sp, input logic sd, input logic ws,
                                input logic [31:0] data, input logic rd, input logic clr,
                                input logic [15:0] fl, input logic [7:0] sk, input logic [1:0] cs,
                                input logic eb, input logic ee, input logic ef, input logic [2:0] el,
                                input logic [23:0] er, input logic efd, input logic eov);
        vec_t v;
        v.st = st; v.sp = sp; v.sd = sd; v.ws = ws; v.data = data; v.rd = rd; v.clr = clr;
        v.fl = fl; v.sk = sk; v.cs = cs;
        v.e_busy = eb; v.e_empty = ee; v.e_full = ef; v.e_lvl = el; v.e_rdata = er;
        v.e_fd = efd; v.e_ovr = eov;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_in();
        start = 0; stop = 0; s_done = 0; s_ws = 0; s_data = '0; fifo_rd = 0; clr_ovr = 0;
        frame_len = '0; skip_cnt = '0; chan_sel = '0;
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        clr_in();
    endtask

    task automatic strobe(input logic ws, input logic [31:0] d, input logic rd);
        s_done = 1; s_ws = ws; s_data = d; fifo_rd = rd;
        tick();
    endtask

    task automatic do_start(input logic [15:0] fl, input logic [7:0] sk, input logic [1:0] cs);
        start = 1; frame_len = fl; skip_cnt = sk; chan_sel = cs;
        tick();
    endtask

    initial begin
        bit fd_seen;
        clr_in();
        HRESET = 1;
        #2;
        chk("reset busy", busy, 0);
        chk("reset i2s_en", i2s_en, 0);
        chk("reset empty", fifo_empty, 1);
        chk("reset full", fifo_full, 0);
        chk("reset level", fifo_level, 0);
        chk("reset rdata", fifo_rdata, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset overrun", overrun, 0);
        chk("reset timeout", timeout, 0);
        @(negedge HCLK);
        HRESET = 0;
        @(posedge HCLK);
        #1;

        //          st sp sd ws data          rd clr fl sk cs | busy empty full lvl rdata  fd ovr
        vq.push_back(mk(1,0,0,0,32'h0,         0,0, 4, 2, 0,  1,1,0,0,24'h0,   0,0));
        vq.push_back(mk(0,0,1,0,32'h00010000,  0,0, 0, 0, 0,  1,1,0,0,24'h0,   0,0));
        vq.push_back(mk(0,0,1,1,32'h00010100,  0,0, 0, 0, 0,  1,1,0,0,24'h0,   0,0));
        vq.push_back(mk(0,0,1,0,32'h00010200,  0,0, 0, 0, 0,  1,1,0,0,24'h0,   0,0));
        vq.push_back(mk(0,0,1,1,32'h00010300,  0,0, 0, 0, 0,  1,1,0,0,24'h0,   0,0));
        vq.push_back(mk(0,0,1,0,32'h00010400,  0,0, 0, 0, 0,  1,0,0,1,24'h104, 0,0));
        vq.push_back(mk(0,0,1,1,32'h00010500,  0,0, 0, 0, 0,  1,0,0,1,24'h104, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00010600,  0,0, 0, 0, 0,  1,0,0,2,24'h104, 0,0));
        vq.push_back(mk(0,0,1,1,32'h00010700,  0,0, 0, 0, 0,  1,0,0,2,24'h104, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00010800,  0,0, 0, 0, 0,  1,0,0,3,24'h104, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00010900,  0,0, 0, 0, 0,  0,0,1,4,24'h104, 1,0));
        vq.push_back(mk(0,0,0,0,32'h0,         0,0, 0, 0, 0,  0,0,1,4,24'h104, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,0,0,3,24'h106, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,0,0,2,24'h108, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,0,0,1,24'h109, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,1,0,0,24'h109, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,1,0,0,24'h109, 0,0));
        // both channels, frame of 6 into a 4-deep FIFO with no reads
        vq.push_back(mk(1,0,0,0,32'h0,         0,0, 6, 0, 2,  1,1,0,0,24'h109, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00020000,  0,0, 0, 0, 0,  1,0,0,1,24'h200, 0,0));
        vq.push_back(mk(0,0,1,1,32'h00020100,  0,0, 0, 0, 0,  1,0,0,2,24'h200, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00020200,  0,0, 0, 0, 0,  1,0,0,3,24'h200, 0,0));
        vq.push_back(mk(0,0,1,1,32'h00020300,  0,0, 0, 0, 0,  1,0,1,4,24'h200, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00020400,  0,0, 0, 0, 0,  1,0,1,4,24'h200, 0,1));
        vq.push_back(mk(0,0,1,1,32'h00020500,  0,0, 0, 0, 0,  0,0,1,4,24'h200, 1,1));
        vq.push_back(mk(0,0,0,0,32'h0,         0,1, 0, 0, 0,  0,0,1,4,24'h200, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         0,0, 0, 0, 0,  0,0,1,4,24'h200, 0,0));
        vq.push_back(mk(1,1,0,0,32'h0,         0,0, 3, 0, 0,  0,0,1,4,24'h200, 0,0));
        // full FIFO: strobe and read in the same cycle
        vq.push_back(mk(1,0,0,0,32'h0,         0,0, 0, 0, 0,  1,0,1,4,24'h200, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00030000,  1,0, 0, 0, 0,  1,0,1,4,24'h201, 0,0));
        vq.push_back(mk(0,1,0,0,32'h0,         0,0, 0, 0, 0,  0,0,1,4,24'h201, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,0,0,3,24'h202, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,0,0,2,24'h203, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,0,0,1,24'h300, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,1,0,0,24'h300, 0,0));
        // empty FIFO push+pop; chan_sel change mid-capture ignored
        vq.push_back(mk(1,0,0,0,32'h0,         0,0, 0, 0, 0,  1,1,0,0,24'h300, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00031000,  1,0, 0, 0, 0,  1,0,0,1,24'h310, 0,0));
        vq.push_back(mk(0,0,1,1,32'h00032000,  0,0, 0, 0, 1,  1,0,0,1,24'h310, 0,0));
        vq.push_back(mk(0,1,0,0,32'h0,         0,0, 0, 0, 0,  0,0,0,1,24'h310, 0,0));
        vq.push_back(mk(0,0,0,0,32'h0,         1,0, 0, 0, 0,  0,1,0,0,24'h310, 0,0));
        // stop during warm-up, strobes in idle ignored
        vq.push_back(mk(1,0,0,0,32'h0,         0,0, 2, 3, 0,  1,1,0,0,24'h310, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00040000,  0,0, 0, 0, 0,  1,1,0,0,24'h310, 0,0));
        vq.push_back(mk(0,1,0,0,32'h0,         0,0, 0, 0, 0,  0,1,0,0,24'h310, 0,0));
        vq.push_back(mk(0,0,1,0,32'h00041000,  0,0, 0, 0, 0,  0,1,0,0,24'h310, 0,0));

        foreach (vq[i]) begin
            start = vq[i].st; stop = vq[i].sp; s_done = vq[i].sd; s_ws = vq[i].ws;
            s_data = vq[i].data; fifo_rd = vq[i].rd; clr_ovr = vq[i].clr;
            frame_len = vq[i].fl; skip_cnt = vq[i].sk; chan_sel = vq[i].cs;
            tick();
            chk($sformatf("v%0d busy", i), busy, vq[i].e_busy);
            chk($sformatf("v%0d i2s_en", i), i2s_en, vq[i].e_busy);
            chk($sformatf("v%0d empty", i), fifo_empty, vq[i].e_empty);
            chk($sformatf("v%0d full", i), fifo_full, vq[i].e_full);
            chk($sformatf("v%0d level", i), fifo_level, vq[i].e_lvl);
            chk($sformatf("v%0d rdata", i), fifo_rdata, vq[i].e_rdata);
            chk($sformatf("v%0d frame_done", i), frame_done, vq[i].e_fd);
            chk($sformatf("v%0d overrun", i), overrun, vq[i].e_ovr);
        end

        // continuous capture with steady reads, then stop
        do_start(16'd0, 8'd0, 2'b10);
        fd_seen = 0;
        for (int k = 0; k < 20; k++) begin
            strobe(k[0], (32'h400 + 32'(k)) << 8, 1'b1);
            fd_seen |= frame_done;
            chk($sformatf("cont level %0d", k), fifo_level, 1);
            chk($sformatf("cont rdata %0d", k), fifo_rdata, 24'h400 + 24'(k));
        end
        stop = 1;
        tick();
        fd_seen |= frame_done;
        chk("cont no frame_done", fd_seen, 0);
        chk("cont stop i2s_en", i2s_en, 0);
        chk("cont stop level", fifo_level, 1);
        chk("cont stop rdata", fifo_rdata, 24'h413);
        fifo_rd = 1;
        tick();
        chk("cont drained", fifo_empty, 1);

        // asynchronous reset mid-capture
        do_start(16'd0, 8'd0, 2'b10);
        for (int k = 0; k < 5; k++) strobe(k[0], (32'h500 + 32'(k)) << 8, 1'b0);
        chk("pre-rst overrun", overrun, 1);
        fifo_rd = 1;
        tick();
        chk("pre-rst level", fifo_level, 3);
        chk("pre-rst busy", busy, 1);
        #2 HRESET = 1;
        #1;
        chk("async rst empty", fifo_empty, 1);
        chk("async rst busy", busy, 0);
        chk("async rst i2s_en", i2s_en, 0);
        chk("async rst overrun", overrun, 0);
        chk("async rst level", fifo_level, 0);
        chk("async rst rdata", fifo_rdata, 0);
        @(negedge HCLK);
        HRESET = 0;
        @(posedge HCLK);
        #1;
        do_start(16'd1, 8'd0, 2'b00);
        chk("post-rst busy", busy, 1);
        strobe(1'b0, 32'h00ABCD00, 1'b0);
        chk("post-rst frame_done", frame_done, 1);
        chk("post-rst busy off", busy, 0);
        chk("post-rst rdata", fifo_rdata, 24'h00ABCD);
        chk("post-rst level", fifo_level, 1);

        // watchdog
        do_start(16'd0, 8'd0, 2'b00);
`ifdef I2S_CAPTURE_TIMEOUT_EN
        for (int k = 0; k < 99; k++) tick();
        chk("wdog busy at 100", busy, 1);
        chk("wdog timeout at 100", timeout, 0);
        tick();
        chk("wdog timeout at 101", timeout, 1);
        chk("wdog busy at 101", busy, 0);
        chk("wdog i2s_en at 101", i2s_en, 0);
        chk("wdog no frame_done", frame_done, 0);
        do_start(16'd0, 8'd0, 2'b00);
        chk("wdog cleared by start", timeout, 0);
        chk("wdog restart busy", busy, 1);
`else
        for (int k = 0; k < 1000; k++) tick();
        chk("no wdog busy", busy, 1);
        chk("no wdog timeout", timeout, 0);
`endif
        stop = 1;
        tick();
        chk("final idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
